// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: self-timed stopwatch core. A prescaler divides the system
// clock down to the tick rate and a single increment event advances a
// cascaded BCD digit chain in one edge. Also provides run/pause, clear,
// lap-hold snapshot, MM:SS.cc digit limits and wrap/saturate overflow.
module stopwatch_bcd #(
    parameter int unsigned CLOCK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned MMSS_MODE = 0,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [4*DIGITS-1:0]   display_bcd,
    output logic                  lap_held,
    output logic                  tick,
    output logic                  overflow
);

    localparam int unsigned DIV = CLOCK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(DIV - 1);

    // Seconds-tens and minutes-tens only count to 5 in MM:SS.cc mode.
    function automatic logic [3:0] digitLimit(input int idx);
        if (MMSS_MODE != 0 && (idx == 3 || idx == 5)) begin
            return 4'd5;
        end
        return 4'd9;
    endfunction

    logic [PW-1:0]         prescale_q, prescale_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic [4*DIGITS-1:0]   display_q, display_d;
    logic                  lapHeld_q, lapHeld_d;
    logic                  tick_q, tick_d;
    logic                  overflow_q, overflow_d;

    logic                  incEvent;
    logic                  atFull;
    logic                  carry;
    logic [4*DIGITS-1:0]   countInc;

    // Incremented digit chain: a digit steps only when every lower digit sits at its limit.
    always_comb begin
        atFull   = 1'b1;
        carry    = 1'b1;
        countInc = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != digitLimit(i)) begin
                atFull = 1'b0;
            end
            if (carry) begin
                if (count_q[4*i +: 4] == digitLimit(i)) begin
                    countInc[4*i +: 4] = 4'd0;
                end else begin
                    countInc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                end
            end
            carry = carry && (count_q[4*i +: 4] == digitLimit(i));
        end
    end

    // Next-state: clear beats increment and lap; saturation suppresses the count step and tick.
    always_comb begin
        incEvent   = run && (prescale_q == PRESCALE_MAX);
        prescale_d = prescale_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        lapHeld_d  = lapHeld_q;
        tick_d     = 1'b0;
        if (clear) begin
            prescale_d = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            lapHeld_d  = 1'b0;
        end else begin
            if (run) begin
                prescale_d = incEvent ? '0 : prescale_q + 1'b1;
            end
            if (incEvent) begin
                if (atFull) begin
                    overflow_d = 1'b1;
                end
                if (!(atFull && SATURATE != 0)) begin
                    count_d = countInc;
                    tick_d  = 1'b1;
                end
            end
            if (lap) begin
                lapHeld_d = !lapHeld_q;
            end
        end
        display_d = (lapHeld_d && lapHeld_q) ? display_q : count_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            prescale_q <= '0;
            count_q    <= '0;
            display_q  <= '0;
            lapHeld_q  <= 1'b0;
            tick_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            count_q    <= count_d;
            display_q  <= display_d;
            lapHeld_q  <= lapHeld_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_bcd   = count_q;
    assign display_bcd = display_q;
    assign lap_held    = lapHeld_q;
    assign tick        = tick_q;
    assign overflow    = overflow_q;

endmodule
